// File: rtl/icache_line_fill_unit.sv
// Memory-side line fill for the pipelined icache: demand reads and next-line prefetches
// share one burst engine; demand has priority and may promote an in-flight prefetch.
module icache_line_fill_unit #(
    parameter int unsigned BEATS     = 4,
    parameter int unsigned BEAT_W    = 64,
    parameter bit          PF_ENABLE = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               dfp_addr,
    input  logic                      dfp_read,
    output logic [BEATS*BEAT_W-1:0]   dfp_rdata,
    output logic                      dfp_resp,
    input  logic                      pf_valid,
    input  logic [31:0]               pf_addr,
    output logic                      pf_resp,
    output logic [31:0]               pf_resp_addr,
    output logic [BEATS*BEAT_W-1:0]   pf_rdata,
    output logic [31:0]               mem_addr,
    output logic                      mem_read,
    input  logic                      mem_ready,
    input  logic [BEAT_W-1:0]         mem_rdata,
    input  logic                      mem_rvalid
);

    localparam int unsigned LINE_W = BEATS * BEAT_W;
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned TAG_W  = 32 - OFF_W;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RECV,
        RESP
    } state_t;

    state_t             state, state_next;
    logic [TAG_W-1:0]   line;
    logic [TAG_W-1:0]   lp_line;
    logic               lp_valid;
    logic               req_is_pf;
    logic               promote;
    logic [CNT_W-1:0]   beat_cnt;
    logic [LINE_W-1:0]  line_buf;

    logic [TAG_W-1:0]   dfp_line;
    logic [TAG_W-1:0]   pf_line;
    logic               pf_take;
    logic               last_beat;
    logic               unused_addr_bits;

    assign dfp_line         = dfp_addr[31:OFF_W];
    assign pf_line          = pf_addr[31:OFF_W];
    assign unused_addr_bits = ^{dfp_addr[OFF_W-1:0], pf_addr[OFF_W-1:0]};
    // lp_line remembers the most recent prefetched or demanded line to suppress repeats
    assign pf_take   = PF_ENABLE && pf_valid && !(lp_valid && (lp_line == pf_line));
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_next   = state;
        mem_read     = 1'b0;
        mem_addr     = '0;
        dfp_resp     = 1'b0;
        dfp_rdata    = '0;
        pf_resp      = 1'b0;
        pf_rdata     = '0;
        pf_resp_addr = '0;
        case (state)
            IDLE: begin
                if (dfp_read || pf_take) state_next = ISSUE;
            end
            ISSUE: begin
                mem_read = 1'b1;
                mem_addr = {line, {OFF_W{1'b0}}};
                if (mem_ready) state_next = RECV;
            end
            RECV: begin
                if (mem_rvalid && last_beat) state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
                // a promoted prefetch is answered on the demand port only
                if (!req_is_pf || promote) begin
                    dfp_resp  = 1'b1;
                    dfp_rdata = line_buf;
                end else begin
                    pf_resp      = 1'b1;
                    pf_rdata     = line_buf;
                    pf_resp_addr = {line, {OFF_W{1'b0}}};
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            line      <= '0;
            lp_line   <= '0;
            lp_valid  <= 1'b0;
            req_is_pf <= 1'b0;
            promote   <= 1'b0;
            beat_cnt  <= '0;
            line_buf  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (dfp_read) begin
                        line      <= dfp_line;
                        req_is_pf <= 1'b0;
                        promote   <= 1'b0;
                    end else if (pf_take) begin
                        line      <= pf_line;
                        req_is_pf <= 1'b1;
                        promote   <= 1'b0;
                        lp_line   <= pf_line;
                        lp_valid  <= 1'b1;
                    end
                end
                ISSUE, RECV: begin
                    if (req_is_pf && dfp_read && (dfp_line == line)) promote <= 1'b1;
                end
                RESP: begin
                    if (!req_is_pf || promote) begin
                        lp_line  <= line;
                        lp_valid <= 1'b1;
                    end
                    promote <= 1'b0;
                end
                default: ;
            endcase
            if ((state == RECV) && mem_rvalid) begin
                for (int unsigned b = 0; b < BEATS; b++) begin
                    if (beat_cnt == CNT_W'(b)) line_buf[b*BEAT_W +: BEAT_W] <= mem_rdata;
                end
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_line_fill_unit.sv
// Bench for icache_line_fill_unit: memory stub plus transaction-level reference model,
// directed scenarios followed by randomized demand/prefetch traffic.
module tb_icache_line_fill_unit;

    localparam int unsigned BEATS    = 4;
    localparam int unsigned EV_DFP   = 0;
    localparam int unsigned EV_PF    = 1;
    localparam int unsigned EV_BURST = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         pf_valid;
    logic [31:0]  pf_addr;
    logic         pf_resp;
    logic [31:0]  pf_resp_addr;
    logic [255:0] pf_rdata;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_ready;
    logic [63:0]  mem_rdata;
    logic         mem_rvalid;

    always #5 clk = ~clk;

    icache_line_fill_unit #(.BEATS(4), .BEAT_W(64), .PF_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_resp(pf_resp),
        .pf_resp_addr(pf_resp_addr), .pf_rdata(pf_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    int unsigned vectors = 0, miscompares = 0;
    bit          chk_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned rdy_pct = 100, rv_pct = 100;
    logic [26:0] st_line = '0;
    int unsigned st_left = 0, st_beat = 0;
    int unsigned burst_cnt = 0, dfp_cnt = 0, pf_cnt = 0;
    logic [31:0] burst_q[$];
    int unsigned last_dfp_cyc = 0, last_pf_cyc = 0;
    logic [31:0] last_pf_addr = '0;
    logic [255:0] last_dfp_data = '0;
    bit          saw_dfp = 1'b0;

    // Memory content is a pure function of line and beat, so any line's data is predictable.
    function automatic logic [63:0] mem_word(input logic [26:0] ln, input int unsigned k);
        return {ln, 5'b0, 32'hA5A5_0000 | 32'(k)};
    endfunction

    function automatic logic [255:0] line_data(input logic [26:0] ln);
        logic [255:0] d;
        d = '0;
        for (int unsigned k = 0; k < BEATS; k++) d[k*64 +: 64] = mem_word(ln, k);
        return d;
    endfunction

    function automatic int unsigned evt_cnt(input int unsigned kind);
        case (kind)
            EV_DFP:  return dfp_cnt;
            EV_PF:   return pf_cnt;
            default: return burst_cnt;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        saw_dfp = dfp_resp;
        if (dfp_resp) begin dfp_cnt++; last_dfp_cyc = cyc; last_dfp_data = dfp_rdata; end
        if (pf_resp)  begin pf_cnt++;  last_pf_cyc = cyc;  last_pf_addr = pf_resp_addr; end
        if (mem_rvalid && st_left > 0) begin st_left--; st_beat++; end
        if (mem_read && mem_ready) begin
            burst_cnt++;
            burst_q.push_back(mem_addr);
            st_line = mem_addr[31:5];
            st_left = BEATS;
            st_beat = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_ready = ($urandom_range(99) < rdy_pct);
        if (st_left > 0 && $urandom_range(99) < rv_pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(st_line, st_beat);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
        end
    endtask

    task automatic wait_evt(input int unsigned kind, input string nm);
        int unsigned c0;
        int unsigned n;
        c0 = evt_cnt(kind);
        n  = 0;
        while (evt_cnt(kind) == c0 && n < 200) begin tick(); n++; end
        chk(nm, 256'(evt_cnt(kind) - c0), 256'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_dfp_resp"}, 256'(dfp_resp), '0);
        chk({nm, "_pf_resp"}, 256'(pf_resp), '0);
        chk({nm, "_mem_read"}, 256'(mem_read), '0);
        chk({nm, "_mem_addr"}, 256'(mem_addr), '0);
        chk({nm, "_dfp_rdata"}, dfp_rdata, '0);
        chk({nm, "_pf_rdata"}, pf_rdata, '0);
        chk({nm, "_pf_resp_addr"}, 256'(pf_resp_addr), '0);
    endtask

    // Reference model: one outstanding transaction described by flags and a beat count.
    initial begin : compare
        logic        m_busy, m_acc, m_resp, m_pf, m_prom, m_lpv;
        logic [26:0] m_line, m_lp;
        int unsigned m_beats;
        logic        exp_mr, exp_dr, exp_pr;
        logic [255:0] exp_line;
        m_busy = 0; m_acc = 0; m_resp = 0; m_pf = 0; m_prom = 0; m_lpv = 0;
        m_line = '0; m_lp = '0; m_beats = 0;
        forever begin
            @(negedge clk);
            exp_mr   = m_busy && !m_acc;
            exp_dr   = m_resp && (!m_pf || m_prom);
            exp_pr   = m_resp && m_pf && !m_prom;
            exp_line = line_data(m_line);
            if (chk_en) begin
                chk("mem_read", 256'(mem_read), 256'(exp_mr));
                if (exp_mr) chk("mem_addr", 256'(mem_addr), 256'({m_line, 5'b0}));
                chk("dfp_resp", 256'(dfp_resp), 256'(exp_dr));
                chk("pf_resp", 256'(pf_resp), 256'(exp_pr));
                chk("dfp_rdata", dfp_rdata, exp_dr ? exp_line : '0);
                chk("pf_rdata", pf_rdata, exp_pr ? exp_line : '0);
                if (exp_pr) chk("pf_resp_addr", 256'(pf_resp_addr), 256'({m_line, 5'b0}));
            end
            if (rst) begin
                m_busy = 0; m_acc = 0; m_resp = 0; m_pf = 0; m_prom = 0; m_lpv = 0; m_beats = 0;
            end else if (m_resp) begin
                if (!m_pf || m_prom) begin m_lp = m_line; m_lpv = 1; end
                m_busy = 0; m_resp = 0; m_prom = 0;
            end else if (!m_busy) begin
                if (dfp_read) begin
                    m_busy = 1; m_acc = 0; m_beats = 0; m_pf = 0; m_prom = 0;
                    m_line = dfp_addr[31:5];
                end else if (pf_valid && !(m_lpv && m_lp == pf_addr[31:5])) begin
                    m_busy = 1; m_acc = 0; m_beats = 0; m_pf = 1; m_prom = 0;
                    m_line = pf_addr[31:5];
                    m_lp = pf_addr[31:5]; m_lpv = 1;
                end
            end else begin
                if (m_pf && dfp_read && dfp_addr[31:5] == m_line) m_prom = 1;
                if (!m_acc) m_acc = mem_ready;
                else if (mem_rvalid) begin
                    m_beats++;
                    if (m_beats == BEATS) m_resp = 1;
                end
            end
        end
    end

    initial begin : drive
        int unsigned t0, b0, p0, d0, dem_wait;
        rst = 1; dfp_read = 0; dfp_addr = '0; pf_valid = 0; pf_addr = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 0;
        chk_en = 1;
        tick();

        // 1: demand latency and beat ordering
        rdy_pct = 100; rv_pct = 100;
        dfp_addr = 32'h0000_1040; dfp_read = 1; t0 = cyc;
        tick();
        chk("t1_mem_read", 256'(mem_read), 256'd1);
        chk("t1_mem_addr", 256'(mem_addr), 256'h1040);
        wait_evt(EV_DFP, "t1_dfp_done");
        dfp_read = 0;
        chk("t1_latency", 256'(last_dfp_cyc), 256'(t0 + 6));
        chk("t1_beat0", 256'(last_dfp_data[63:0]), 256'h0000_1040_A5A5_0000);
        chk("t1_beat3", 256'(last_dfp_data[255:192]), 256'h0000_1040_A5A5_0003);
        tick();

        // 2: a held prefetch candidate is fetched once
        b0 = burst_cnt; p0 = pf_cnt;
        pf_addr = 32'h0000_1060; pf_valid = 1;
        repeat (20) tick();
        pf_valid = 0;
        chk("t2_bursts", 256'(burst_cnt - b0), 256'd1);
        chk("t2_pf_count", 256'(pf_cnt - p0), 256'd1);
        chk("t2_pf_addr", 256'(last_pf_addr), 256'h1060);

        // 3: simultaneous demand and prefetch
        b0 = burst_cnt; p0 = pf_cnt;
        dfp_addr = 32'h0000_2000; dfp_read = 1;
        pf_addr = 32'h0000_2020; pf_valid = 1;
        wait_evt(EV_DFP, "t3_dfp_done");
        dfp_read = 0;
        if (pf_cnt == p0) wait_evt(EV_PF, "t3_pf_done");
        pf_valid = 0;
        chk("t3_order", 256'(last_dfp_cyc < last_pf_cyc), 256'd1);
        chk("t3_burst0", 256'(burst_q[b0]), 256'h2000);
        chk("t3_burst1", 256'(burst_q[b0 + 1]), 256'h2020);

        // 4: same-line demand promotes the in-flight prefetch
        b0 = burst_cnt; p0 = pf_cnt;
        pf_addr = 32'h0000_3000; pf_valid = 1;
        tick();
        pf_valid = 0;
        wait_evt(EV_BURST, "t4_pf_issue");
        dfp_addr = 32'h0000_3000; dfp_read = 1;
        wait_evt(EV_DFP, "t4_dfp_done");
        dfp_read = 0;
        repeat (5) tick();
        chk("t4_bursts", 256'(burst_cnt - b0), 256'd1);
        chk("t4_no_pf", 256'(pf_cnt - p0), 256'd0);
        chk("t4_beat0", 256'(last_dfp_data[63:0]), 256'h0000_3000_A5A5_0000);

        // 5: different-line demand waits; stalled issue holds address
        rst = 1; tick(); tick(); rst = 0;
        b0 = burst_cnt; p0 = pf_cnt;
        pf_addr = 32'h0000_3000; pf_valid = 1;
        tick();
        pf_valid = 0;
        wait_evt(EV_BURST, "t5_pf_issue");
        dfp_addr = 32'h0000_4000; dfp_read = 1;
        wait_evt(EV_PF, "t5_pf_done");
        chk("t5_pf_addr", 256'(last_pf_addr), 256'h3000);
        rdy_pct = 0; mem_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_read", 256'(mem_read), 256'd1);
            chk("t5_stall_addr", 256'(mem_addr), 256'h4000);
            tick();
        end
        rdy_pct = 100; mem_ready = 1;
        wait_evt(EV_DFP, "t5_dfp_done");
        dfp_read = 0;
        chk("t5_order", 256'(last_pf_cyc < last_dfp_cyc), 256'd1);
        chk("t5_burst1", 256'(burst_q[b0 + 1]), 256'h4000);

        // 6: reset after two beats, then stray beats
        p0 = pf_cnt; d0 = dfp_cnt;
        dfp_addr = 32'h0000_4800; dfp_read = 1;
        wait_evt(EV_BURST, "t6_issue");
        tick();
        tick();
        rst = 1; mem_rvalid = 0; dfp_read = 0; rv_pct = 0;
        tick();
        rst = 0;
        chk_all_zero("t6_after_rst");
        rv_pct = 100;
        repeat (6) tick();
        chk("t6_no_resp", 256'((dfp_cnt - d0) + (pf_cnt - p0)), 256'd0);
        dfp_addr = 32'h0000_5000; dfp_read = 1;
        wait_evt(EV_DFP, "t6_dfp_done");
        dfp_read = 0;
        chk("t6_beat1", 256'(last_dfp_data[127:64]), 256'h0000_5000_A5A5_0001);
        tick();

        // randomized traffic over a small set of lines
        rdy_pct = 70; rv_pct = 75; dem_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            pf_valid = ($urandom_range(99) < 40);
            pf_addr  = {27'h100 + 27'($urandom_range(5)), 5'($urandom)};
            rst      = ($urandom_range(999) == 0);
            tick();
            if (dfp_read) begin
                dem_wait++;
                if (saw_dfp) dfp_read = 0;
                else if (dem_wait > 300) begin
                    chk("rand_dfp_timeout", 256'd0, 256'd1);
                    dfp_read = 0;
                end
            end else if ($urandom_range(99) < 15) begin
                dfp_addr = {27'h100 + 27'($urandom_range(5)), 5'($urandom)};
                dfp_read = 1;
                dem_wait = 0;
            end
        end
        rst = 0; pf_valid = 0;
        if (dfp_read) wait_evt(EV_DFP, "rand_final_dfp");
        dfp_read = 0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
